// File: rtl/hazard_control_unit.sv
// Decode, forwarding-select, load-use stall and decode-stage branch control for the 5-stage pipe.
// A shadow E/M/W pipeline tracks destination registers of instructions ahead of decode.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcodeD,
  input  logic [5:0]       funct,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rdD,
  input  logic             eq,
  output logic             regWrite,
  output logic             regDst,
  output logic             memWrite,
  output logic             mem2Reg,
  output logic             aluSrcB,
  output logic [2:0]       aluControl,
  output logic             pcSrc,
  output logic [1:0]       fad,
  output logic [1:0]       fbd,
  output logic             stall,
  output logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef struct packed {
    logic       wr;
    logic       load;
    logic [4:0] dest;
  } stage_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;

  stage_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic illegal_q, illegal_d;

  logic       dec_reg_write, dec_reg_dst, dec_mem_write, dec_mem2reg, dec_alu_src_b;
  logic [2:0] dec_alu_ctrl;
  logic       dec_illegal, dec_beq, use_rs, use_rt;
  logic       haz_rs, haz_rt;
  logic [2:0] fwd_rs, fwd_rt;

  // Returns {hazard, select} for one decode-stage source.
  function automatic logic [2:0] fwd_sel(input logic used, input logic [4:0] src,
                                         input stage_t e, input stage_t m, input stage_t w);
    logic [2:0] r;
    r = 3'b000;
    if (used && src != 5'd0) begin
      if (e.wr && e.dest == src) begin
        r = e.load ? 3'b100 : 3'b001;
      end else if (m.wr && m.dest == src) begin
        r = m.load ? 3'b010 : 3'b011;
      end else if (w.wr && w.dest == src) begin
        // Register file writes before it reads, so W needs no bypass.
        r = 3'b000;
      end
    end
    return r;
  endfunction

  always_comb begin
    dec_reg_write = 1'b0;
    dec_reg_dst   = 1'b0;
    dec_mem_write = 1'b0;
    dec_mem2reg   = 1'b0;
    dec_alu_src_b = 1'b0;
    dec_alu_ctrl  = 3'b000;
    dec_illegal   = 1'b0;
    dec_beq       = 1'b0;
    use_rs        = 1'b0;
    use_rt        = 1'b0;
    case (opcodeD)
      OpRtype: begin
        if (funct != 6'b000000) begin
          dec_reg_write = 1'b1;
          dec_reg_dst   = 1'b1;
          use_rs        = 1'b1;
          use_rt        = 1'b1;
          case (funct)
            6'b100000: dec_alu_ctrl = 3'b010;
            6'b100010: dec_alu_ctrl = 3'b110;
            6'b100100: dec_alu_ctrl = 3'b000;
            6'b100101: dec_alu_ctrl = 3'b001;
            6'b101010: dec_alu_ctrl = 3'b111;
            default: begin
              dec_illegal   = 1'b1;
              dec_reg_write = 1'b0;
              dec_reg_dst   = 1'b0;
              use_rs        = 1'b0;
              use_rt        = 1'b0;
            end
          endcase
        end
      end
      OpLw: begin
        dec_reg_write = 1'b1;
        dec_mem2reg   = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_alu_ctrl  = 3'b010;
        use_rs        = 1'b1;
      end
      OpSw: begin
        dec_mem_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_alu_ctrl  = 3'b010;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OpAddi: begin
        dec_reg_write = 1'b1;
        dec_alu_src_b = 1'b1;
        dec_alu_ctrl  = 3'b010;
        use_rs        = 1'b1;
      end
      OpBeq: begin
        dec_alu_ctrl = 3'b110;
        dec_beq      = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    fwd_rs = fwd_sel(use_rs, rsD, e_q, m_q, w_q);
    fwd_rt = fwd_sel(use_rt, rtD, e_q, m_q, w_q);
    haz_rs = fwd_rs[2];
    haz_rt = fwd_rt[2];
    fad    = fwd_rs[1:0];
    fbd    = fwd_rt[1:0];
    stall  = haz_rs | haz_rt;

    regWrite   = dec_reg_write & ~stall;
    memWrite   = dec_mem_write & ~stall;
    regDst     = dec_reg_dst;
    mem2Reg    = dec_mem2reg;
    aluSrcB    = dec_alu_src_b;
    aluControl = dec_alu_ctrl;
    pcSrc      = dec_beq & eq & ~stall;
    flush      = pcSrc;
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.wr   = dec_reg_write;
      e_d.load = dec_mem2reg;
      e_d.dest = dec_reg_dst ? rdD : rtD;
    end
    m_d = e_q;
    w_d = m_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);

    illegal_d = illegal_q | (dec_illegal & ~stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; small counter width exposes saturation.
module tb_hazard_control_unit;

  localparam int unsigned CW = 3;

  logic          clk, rst;
  logic [5:0]    opcodeD, funct;
  logic [4:0]    rsD, rtD, rdD;
  logic          eq;
  logic          regWrite, regDst, memWrite, mem2Reg, aluSrcB;
  logic [2:0]    aluControl;
  logic          pcSrc, stall, flush, illegal;
  logic [1:0]    fad, fbd;
  logic [CW-1:0] stallCount, flushCount;

  int vectors = 0;
  int miscompares = 0;

  hazard_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcodeD(opcodeD), .funct(funct), .rsD(rsD), .rtD(rtD),
    .rdD(rdD), .eq(eq), .regWrite(regWrite), .regDst(regDst), .memWrite(memWrite),
    .mem2Reg(mem2Reg), .aluSrcB(aluSrcB), .aluControl(aluControl), .pcSrc(pcSrc),
    .fad(fad), .fbd(fbd), .stall(stall), .flush(flush), .illegal(illegal),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn);
    opcodeD = op; rsD = rs; rtD = rt; rdD = rd; funct = fn;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    eq  = 1'b0;
    instr(6'd0, 5'd0, 5'd0, 5'd0, 6'd0);
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    vectors++;
    if ({regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl} !== 8'd0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 0",
        {regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl});
    end
    vectors++;
    if ({fad, fbd, stall, flush, pcSrc} !== 7'd0) begin
      miscompares++; $display("FAIL reset_hz got %b exp 0", {fad, fbd, stall, flush, pcSrc});
    end
    vectors++;
    if ({stallCount, flushCount, illegal} !== 7'd0) begin
      miscompares++; $display("FAIL reset_cnt got %b exp 0", {stallCount, flushCount, illegal});
    end
  endtask

  task automatic test_alu_forward();
    reset_dut();
    instr(6'b000000, 5'd1, 5'd2, 5'd3, 6'b100000);  // add $3,$1,$2
    step();
    instr(6'b000000, 5'd3, 5'd1, 5'd4, 6'b100010);  // sub $4,$3,$1
    vectors++;
    if ({fad, fbd, stall, regWrite, aluControl} !== {2'd1, 2'd0, 1'b0, 1'b1, 3'b110}) begin
      miscompares++; $display("FAIL alu_fwd_e got %b exp %b",
        {fad, fbd, stall, regWrite, aluControl}, {2'd1, 2'd0, 1'b0, 1'b1, 3'b110});
    end
    step();
    instr(6'b000000, 5'd3, 5'd4, 5'd8, 6'b100101);  // or $8,$3,$4
    vectors++;
    if ({fad, fbd, stall, aluControl} !== {2'd3, 2'd1, 1'b0, 3'b001}) begin
      miscompares++; $display("FAIL alu_fwd_m got %b exp %b",
        {fad, fbd, stall, aluControl}, {2'd3, 2'd1, 1'b0, 3'b001});
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    instr(6'b100011, 5'd0, 5'd5, 5'd0, 6'd0);  // lw $5,0($0)
    vectors++;
    if ({regWrite, mem2Reg, aluSrcB, aluControl} !== {3'b111, 3'b010}) begin
      miscompares++; $display("FAIL lw_decode got %b exp 111010",
        {regWrite, mem2Reg, aluSrcB, aluControl});
    end
    step();
    instr(6'b000000, 5'd5, 5'd5, 5'd6, 6'b100000);  // add $6,$5,$5
    vectors++;
    if ({stall, regWrite, memWrite, flush} !== 4'b1000) begin
      miscompares++; $display("FAIL lu_stall got %b exp 1000", {stall, regWrite, memWrite, flush});
    end
    step();
    vectors++;
    if ({fad, fbd, stall, regWrite} !== {2'd2, 2'd2, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL lu_fwd got %b exp 101001", {fad, fbd, stall, regWrite});
    end
    vectors++;
    if (stallCount !== 3'd1) begin
      miscompares++; $display("FAIL lu_count got %0d exp 1", stallCount);
    end
  endtask

  task automatic test_branch();
    reset_dut();
    eq = 1'b1;
    instr(6'b000100, 5'd1, 5'd1, 5'd0, 6'd0);  // beq $1,$1
    vectors++;
    if ({pcSrc, flush, stall, regWrite, aluControl} !== {4'b1100, 3'b110}) begin
      miscompares++; $display("FAIL beq_taken got %b exp 1100110",
        {pcSrc, flush, stall, regWrite, aluControl});
    end
    step();
    vectors++;
    if (flushCount !== 3'd1) begin
      miscompares++; $display("FAIL beq_count got %0d exp 1", flushCount);
    end
    eq = 1'b0;
    #1;
    vectors++;
    if ({pcSrc, flush} !== 2'b00) begin
      miscompares++; $display("FAIL beq_not_taken got %b exp 00", {pcSrc, flush});
    end
  endtask

  task automatic test_load_branch();
    reset_dut();
    eq = 1'b1;
    instr(6'b100011, 5'd0, 5'd2, 5'd0, 6'd0);  // lw $2
    step();
    instr(6'b000100, 5'd2, 5'd0, 5'd0, 6'd0);  // beq $2,$0
    vectors++;
    if ({stall, pcSrc, flush} !== 3'b100) begin
      miscompares++; $display("FAIL lb_stall got %b exp 100", {stall, pcSrc, flush});
    end
    step();
    vectors++;
    if ({fad, fbd, stall, pcSrc, flush} !== {2'd2, 2'd0, 3'b011}) begin
      miscompares++; $display("FAIL lb_taken got %b exp 1000011", {fad, fbd, stall, pcSrc, flush});
    end
    step();
    vectors++;
    if ({stallCount, flushCount} !== {3'd1, 3'd1}) begin
      miscompares++; $display("FAIL lb_counts got %b exp 001001", {stallCount, flushCount});
    end
  endtask

  task automatic test_zero_and_illegal();
    reset_dut();
    instr(6'b001000, 5'd0, 5'd0, 5'd0, 6'b000101);  // addi $0,$0,5
    step();
    instr(6'b000000, 5'd0, 5'd0, 5'd7, 6'b100000);  // add $7,$0,$0
    vectors++;
    if ({fad, fbd, stall} !== 5'd0) begin
      miscompares++; $display("FAIL zero_reg got %b exp 0", {fad, fbd, stall});
    end
    step();
    instr(6'b111111, 5'd1, 5'd2, 5'd3, 6'd0);
    vectors++;
    if ({illegal, regWrite, memWrite, aluControl} !== 6'd0) begin
      miscompares++; $display("FAIL illegal_pre got %b exp 0",
        {illegal, regWrite, memWrite, aluControl});
    end
    step();
    vectors++;
    if (illegal !== 1'b1) begin
      miscompares++; $display("FAIL illegal_set got %b exp 1", illegal);
    end
    instr(6'd0, 5'd0, 5'd0, 5'd0, 6'd0);
    step();
    vectors++;
    if (illegal !== 1'b1) begin
      miscompares++; $display("FAIL illegal_sticky got %b exp 1", illegal);
    end
    reset_dut();
    instr(6'b000000, 5'd1, 5'd2, 5'd3, 6'b000001);  // bad funct
    vectors++;
    if ({regWrite, regDst} !== 2'b00) begin
      miscompares++; $display("FAIL bad_funct_ctrl got %b exp 00", {regWrite, regDst});
    end
    step();
    vectors++;
    if (illegal !== 1'b1) begin
      miscompares++; $display("FAIL bad_funct_flag got %b exp 1", illegal);
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    instr(6'b100011, 5'd0, 5'd5, 5'd0, 6'd0);
    step();
    instr(6'b000000, 5'd5, 5'd5, 5'd6, 6'b100000);
    step();
    instr(6'b100011, 5'd0, 5'd5, 5'd0, 6'd0);
    step();
    instr(6'b000000, 5'd5, 5'd5, 5'd6, 6'b100000);
    vectors++;
    if ({stall, stallCount} !== {1'b1, 3'd1}) begin
      miscompares++; $display("FAIL mid_pre got %b exp 1001", {stall, stallCount});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({stall, stallCount} !== 4'd0) begin
      miscompares++; $display("FAIL mid_rst got %b exp 0000", {stall, stallCount});
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({fad, fbd, stall, stallCount} !== 8'd0) begin
      miscompares++; $display("FAIL post_rst got %b exp 0", {fad, fbd, stall, stallCount});
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      instr(6'b100011, 5'd0, 5'd5, 5'd0, 6'd0);
      step();
      instr(6'b000000, 5'd5, 5'd5, 5'd6, 6'b100000);
      step();
      step();
    end
    vectors++;
    if (stallCount !== 3'd7) begin
      miscompares++; $display("FAIL stall_sat got %0d exp 7", stallCount);
    end
    eq = 1'b1;
    instr(6'b000100, 5'd1, 5'd1, 5'd0, 6'd0);
    for (int i = 0; i < 9; i++) step();
    vectors++;
    if (flushCount !== 3'd7) begin
      miscompares++; $display("FAIL flush_sat got %0d exp 7", flushCount);
    end
  endtask

  initial begin
    rst = 1'b1;
    eq  = 1'b0;
    opcodeD = '0; funct = '0; rsD = '0; rtD = '0; rdD = '0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_branch();
    test_load_branch();
    test_zero_and_illegal();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Control-and-hazard companion to the 5-stage pipelined datapath. It decodes the instruction held in the decode (IF/ID) register into the datapath control word, computes the decode-stage forward selects `fad`/`fbd`, and detects load-use hazards and stalls on them. It resolves `beq` in decode through `pcSrc`/`flush`. It tracks the E/M/W stages internally with a shadow pipeline and keeps saturating stall/flush counters for performance debug.

## Interface
- `CNT_W`, default 16: width of the `stallCount` and `flushCount` counters.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `opcodeD` input 6: decode-stage opcode, instr[31:26].
- `funct` input 6: decode-stage funct, instr[5:0].
- `rsD`, `rtD` input 5 each: decode-stage source register numbers.
- `eq` input 1: equality of the forwarded rs/rt values in decode.
- `regWrite`, `regDst`, `memWrite`, `mem2Reg`, `aluSrcB` output 1 each: control word entering ID/EX.
- `aluControl` output 3: ALU operation entering ID/EX.
- `pcSrc` output 1: take branch; PC += sign-extended imm.
- `fad`, `fbd` output 2 each: forward select. 0 = register file, 1 = aluOutE, 2 = memDataM, 3 = aluOutM.
- `stall` output 1: hold PC and IF/ID this cycle; control word is a bubble.
- `flush` output 1: clear IF/ID at the next edge.
- `illegal` output 1: sticky flag, an undecodable instruction was seen.
- `stallCount`, `flushCount` output CNT_W each: saturating event counters.

## Operation
**Decode** (combinational; everything not listed is 0):
- R-type (op 000000):
  - funct add 100000 → aluControl 010
  - funct sub 100010 → aluControl 110
  - funct and 100100 → aluControl 000
  - funct or 100101 → aluControl 001
  - funct slt 101010 → aluControl 111
  - all of the above also set regWrite=1, regDst=1.
  - funct 000000 is a NOP.
  - any other funct is illegal.
- lw 100011: regWrite, mem2Reg, aluSrcB; aluControl 010.
- sw 101011: memWrite, aluSrcB; aluControl 010.
- addi 001000: regWrite, aluSrcB; aluControl 010.
- beq 000100: aluControl 110, no writes.
- Any other opcode: illegal, decoded as a NOP.

**Source use:**
- rs is used by R-type (non-NOP), lw, sw, addi, beq.
- rt is used by R-type (non-NOP), sw, beq.
- A source equal to register 0 never creates a hazard.

**Shadow pipeline:**
- Three registers, E, M and W. Each holds {wr, load, dest[4:0]}.
- ID→E entry: wr = regWrite, load = mem2Reg, dest = regDst ? instr[15:11] : rtD.
  - Implementation note: the block's ports carry only rsD/rtD, so the block must receive the rd field. It does so through the port `rdD` (input 5, instr[15:11]). This port is part of the interface.
- Shift order: E→M→W.
- On `stall`, E loads a bubble (all zero); M and W still shift.

**Forward/stall per used source s** (priority order):
1. E.wr and E.dest==s and !E.load → select 1.
2. E.wr and E.dest==s and E.load → hazard; select 0.
3. M.wr and M.dest==s → select 2 if M.load, else 3.
4. Otherwise → select 0. W-stage hazards are covered by the register file's write-before-read.

**Stall and branch:**
- `stall` = hazard on rs OR hazard on rt.
- While stalled: regWrite, memWrite and pcSrc are forced to 0; the other control outputs are don't-care.
- `pcSrc` = beq & eq & !stall.
- `flush` = pcSrc.
- stall and flush are never both 1.

**Counters and flags:**
- Counters increment at the edge when their event (stall, flush) is high, and hold at all-ones.
- `illegal` sets at the edge when decode is illegal and !stall. It clears only on rst.

## Timing
- Decode, forward, stall, pcSrc and flush are combinational from the inputs and the shadow registers, with zero latency.
- Shadow registers, counters and `illegal` update on the rising clk edge.
- A load followed immediately by a dependent instruction costs exactly 1 stall cycle; in the next cycle that source selects 2.
- An ALU result is forwarded with 0 stall: select 1 when the producer is in E, select 3 when it is in M.
- A taken beq costs 1 flushed slot.
- Reset (async, takes effect at any point, including mid-stall):
  - all shadow stages invalid (wr=0).
  - counters 0, `illegal` 0.
  - with instrD = 0 (NOP): all control outputs 0, fad = fbd = 0, stall = flush = pcSrc = 0.

## Test plan
1. `add $3,$1,$2` then `sub $4,$3,$1` → with sub in D: fad=1, fbd=0, stall=0, regWrite=1, aluControl=110.
2. `lw $5,0($0)` then `add $6,$5,$5` → first cycle: stall=1, regWrite=memWrite=0. Next cycle: fad=fbd=2, stall=0. stallCount=1.
3. `beq $1,$1` with eq=1 and no hazard → pcSrc=1, flush=1. flushCount=1 after the edge. With eq=0 → pcSrc=flush=0.
4. `lw $2` then `beq $2,$0`, eq=1 → 1 cycle with stall=1, pcSrc=0. Next cycle: fad=2, pcSrc=1, flush=1.
5. `addi $0,$0,5` then `add $7,$0,$0` → fad=fbd=0, no stall. Opcode 111111 → illegal=1 after the edge, and it stays set.
6. Assert rst during the stall of scenario 2 → stall drops immediately, stallCount=0. After release, `add` with no producer in E or M → fad=0.
